// File: rtl/spi_slave_rx.sv
// ============================================================================
// Module   : spi_slave_rx
// Purpose  : Oversampling SPI slave receiver (write-only, MSB first) feeding
//            a first-word-fall-through FIFO with a valid/ready interface.
//            Optional MISO echo of the previous word: SPI_SLAVE_RX_MISO_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_slave_rx #(
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk_50m,
  input  logic                          rst_n,
  input  logic                          sck,
  input  logic                          cs,
  input  logic                          mosi,
  input  logic                          rx_ready,
  output logic [DATA_W-1:0]             rx_data,
  output logic                          rx_valid,
  output logic                          rx_overflow,
  output logic                          frame_err,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef SPI_SLAVE_RX_MISO_EN
  ,
  output logic                          miso
`endif
);

  localparam int c_AW = $clog2(FIFO_DEPTH);
  localparam int c_CW = $clog2(DATA_W) + 1;

  localparam logic [c_AW:0]   c_PTR_ONE  = {{c_AW{1'b0}}, 1'b1};
  localparam logic [c_AW:0]   c_FULL_LVL = (c_AW+1)'(FIFO_DEPTH);
  localparam logic [c_CW-1:0] c_CNT_ONE  = {{(c_CW-1){1'b0}}, 1'b1};
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(DATA_W - 1);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_ACTIVE = 2'd1;
  localparam logic [1:0] c_COMMIT = 2'd2;

  // Synchronizers preset high: sck idles high and cs idles inactive.
  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   w_sck_s;
  logic                   w_cs_s;
  logic                   w_mosi_s;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_sck_sync  <= '1;
      r_cs_sync   <= '1;
      r_mosi_sync <= '1;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
    end
  end

  assign w_sck_s  = r_sck_sync[SYNC_STAGES-1];
  assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

  // Edge events are registered together with mosi and cs level so all stay aligned.
  logic r_sck_prev;
  logic r_cs_prev;
  logic r_sck_rise;
  logic r_cs_fall;
  logic r_cs_rise;
  logic r_cs_low;
  logic r_mosi_d;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_sck_prev <= 1'b1;
      r_cs_prev  <= 1'b1;
      r_sck_rise <= 1'b0;
      r_cs_fall  <= 1'b0;
      r_cs_rise  <= 1'b0;
      r_cs_low   <= 1'b0;
      r_mosi_d   <= 1'b1;
    end else begin
      r_sck_prev <= w_sck_s;
      r_cs_prev  <= w_cs_s;
      r_sck_rise <= w_sck_s & ~r_sck_prev;
      r_cs_fall  <= ~w_cs_s & r_cs_prev;
      r_cs_rise  <= w_cs_s & ~r_cs_prev;
      r_cs_low   <= ~w_cs_s;
      r_mosi_d   <= w_mosi_s;
    end
  end

  logic [1:0]        r_state;
  logic [c_CW-1:0]   r_bit_cnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_frame_err;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        c_IDLE: begin
          r_bit_cnt <= '0;
          if (r_cs_fall) begin
            r_state <= c_ACTIVE;
            r_shift <= '0;
          end
        end
        c_ACTIVE: begin
          // cs rise wins over a coincident sck rise
          if (r_cs_rise) begin
            r_frame_err <= (r_bit_cnt != '0);
            r_bit_cnt   <= '0;
            r_state     <= c_IDLE;
          end else if (r_sck_rise) begin
            r_shift   <= {r_shift[DATA_W-2:0], r_mosi_d};
            r_bit_cnt <= r_bit_cnt + c_CNT_ONE;
            if (r_bit_cnt == c_CNT_LAST) begin
              r_state <= c_COMMIT;
            end
          end
        end
        c_COMMIT: begin
          r_bit_cnt <= '0;
          r_state   <= r_cs_low ? c_ACTIVE : c_IDLE;
        end
        default: begin
          r_state   <= c_IDLE;
          r_bit_cnt <= '0;
        end
      endcase
    end
  end

  // FIFO with an extra wrap bit on each pointer.
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [c_AW:0]     r_wr_ptr;
  logic [c_AW:0]     r_rd_ptr;
  logic [c_AW:0]     w_level;
  logic [c_AW:0]     w_wr_next;
  logic [c_AW:0]     w_rd_next;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic              w_push_ok;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_rx_overflow;

  assign w_level   = r_wr_ptr - r_rd_ptr;
  assign w_full    = (w_level == c_FULL_LVL);
  assign w_push    = (r_state == c_COMMIT);
  assign w_pop     = rx_valid & rx_ready;
  assign w_push_ok = w_push & (~w_full | w_pop);
  assign w_wr_next = w_push_ok ? (r_wr_ptr + c_PTR_ONE) : r_wr_ptr;
  assign w_rd_next = w_pop ? (r_rd_ptr + c_PTR_ONE) : r_rd_ptr;

  always_ff @(posedge clk_50m) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr[c_AW-1:0]] <= r_shift;
    end
  end

  // rx_data tracks the next head word and simply holds when the FIFO drains.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_rx_data     <= '0;
      r_rx_overflow <= 1'b0;
    end else begin
      r_wr_ptr      <= w_wr_next;
      r_rd_ptr      <= w_rd_next;
      r_rx_overflow <= w_push & w_full & ~w_pop;
      if (w_wr_next != w_rd_next) begin
        if (w_push_ok && (w_rd_next == r_wr_ptr)) begin
          r_rx_data <= r_shift;
        end else begin
          r_rx_data <= r_mem[w_rd_next[c_AW-1:0]];
        end
      end
    end
  end

  assign rx_data     = r_rx_data;
  assign rx_valid    = (w_level != '0);
  assign rx_overflow = r_rx_overflow;
  assign frame_err   = r_frame_err;
  assign busy        = (r_state != c_IDLE);
  assign fifo_level  = w_level;

`ifdef SPI_SLAVE_RX_MISO_EN
  logic r_sck_fall;
  logic [DATA_W-1:0] r_echo;
  logic [DATA_W-1:0] r_last_word;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_sck_fall  <= 1'b0;
      r_echo      <= '0;
      r_last_word <= '0;
    end else begin
      r_sck_fall <= ~w_sck_s & r_sck_prev;
      if (r_state == c_COMMIT) begin
        r_echo      <= r_shift;
        r_last_word <= r_shift;
      end else if ((r_state == c_IDLE) && r_cs_fall) begin
        r_echo <= r_last_word;
      end else if ((r_state == c_ACTIVE) && r_sck_fall) begin
        r_echo <= {r_echo[DATA_W-2:0], 1'b0};
      end
    end
  end

  assign miso = busy ? r_echo[DATA_W-1] : 1'b1;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_rx.sv
// Testbench for spi_slave_rx: randomized SPI frames against a queue-based
// reference model, with a decoupled monitor that checks every FIFO pop.
`default_nettype none
`timescale 1ns/1ps

module tb_spi_slave_rx;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int SYNC  = 2;
  localparam int HALF  = 12;

  logic       clk_50m = 1'b0;
  logic       rst_n;
  logic       sck;
  logic       cs;
  logic       mosi;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_overflow;
  logic       frame_err;
  logic       busy;
  logic [2:0] fifo_level;
`ifdef SPI_SLAVE_RX_MISO_EN
  logic       miso;
  logic [7:0] miso_cap;
  int         cur_byte = -1;
  int         cap_byte = -1;
`endif

  always #10 clk_50m = ~clk_50m;

  spi_slave_rx #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clk_50m    (clk_50m),
    .rst_n      (rst_n),
    .sck        (sck),
    .cs         (cs),
    .mosi       (mosi),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_overflow(rx_overflow),
    .frame_err  (frame_err),
    .busy       (busy),
    .fifo_level (fifo_level)
`ifdef SPI_SLAVE_RX_MISO_EN
    ,
    .miso       (miso)
`endif
  );

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  int         exp_ovf  = 0;
  int         exp_ferr = 0;
  int         mon_ovf  = 0;
  int         mon_ferr = 0;
  bit         rand_rdy = 1'b0;
  bit         meas     = 1'b0;
  int         lat      = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: counts pulses and checks every popped word against the model.
  always @(negedge clk_50m) begin
    if (rst_n) begin
      if (rx_overflow) mon_ovf++;
      if (frame_err) mon_ferr++;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop_unexpected: got word %0h expected none", rx_data);
        end else begin
          check("pop_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_50m);
      #1;
    end
  endtask

  // Reference model: a completed word is stored unless the FIFO already holds
  // DEPTH words, except when a pop lands in the same cycle.
  task automatic word_done(input logic [7:0] b, input bit collide);
    if (collide || exp_q.size() < DEPTH) exp_q.push_back(b);
    else exp_ovf++;
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits, input bit collide);
    for (int k = 0; k < nbits; k++) begin
      if (rand_rdy) rx_ready = (k == DW-1) ? 1'b1 : 1'($urandom_range(0, 1));
`ifdef SPI_SLAVE_RX_MISO_EN
      if (cur_byte == cap_byte) miso_cap[7-k] = miso;
`endif
      sck  = 1'b0;
      mosi = b[7-k];
      tick(HALF);
      sck = 1'b1;
      if (k == DW-1) word_done(b, collide);
      for (int i = 1; i <= HALF; i++) begin
        @(posedge clk_50m);
        #1;
        if (collide && k == DW-1 && i == SYNC+2) rx_ready = 1'b1;
        if (collide && k == DW-1 && i == SYNC+3) rx_ready = 1'b0;
        if (meas && k == DW-1 && lat < 0 && rx_valid) lat = i;
      end
    end
  endtask

  task automatic frame(input logic [7:0] bytes[$], input int abort_bits, input bit collide_last);
    cs = 1'b0;
    tick(6);
    check("busy_in_frame", {31'd0, busy}, 32'd1);
    for (int n = 0; n < bytes.size(); n++) begin
`ifdef SPI_SLAVE_RX_MISO_EN
      cur_byte = n;
`endif
      send_bits(bytes[n], DW, collide_last && (n == bytes.size()-1));
    end
    if (abort_bits > 0) begin
      send_bits(8'($urandom()), abort_bits, 1'b0);
      exp_ferr++;
    end
`ifdef SPI_SLAVE_RX_MISO_EN
    cur_byte = -1;
`endif
    cs = 1'b1;
    tick(10);
    check("busy_after_frame", {31'd0, busy}, 32'd0);
  endtask

  task automatic drain();
    rx_ready = 1'b1;
    tick(2*DEPTH);
    rx_ready = 1'b0;
    tick(2);
    check("drain_level", {29'd0, fifo_level}, 32'd0);
    check("drain_model_empty", exp_q.size(), 0);
  endtask

  initial begin
    logic [7:0] q[$];
    rst_n    = 1'b0;
    sck      = 1'b1;
    cs       = 1'b1;
    mosi     = 1'b1;
    rx_ready = 1'b0;
    tick(3);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("rst_level", {29'd0, fifo_level}, 32'd0);
    check("rst_flags", {29'd0, busy, frame_err, rx_overflow}, 32'd0);
    rst_n = 1'b1;
    tick(5);

    // Single word with latency measurement
    meas = 1'b1;
    q = {8'hA5};
    frame(q, 0, 1'b0);
    meas = 1'b0;
    check("latency", lat, SYNC+3);
    check("single_level", {29'd0, fifo_level}, exp_q.size());
    check("single_valid", {31'd0, rx_valid}, 32'd1);
    check("single_head", {24'd0, rx_data}, {24'd0, exp_q[0]});
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    tick(2);
    check("single_level_after_pop", {29'd0, fifo_level}, 32'd0);
    check("single_hold_data", {24'd0, rx_data}, 32'hA5);
    check("single_no_err", mon_ferr + mon_ovf, 0);

    // Burst into a stalled consumer: fifth word overflows
    q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    frame(q, 0, 1'b0);
    check("burst_level", {29'd0, fifo_level}, exp_q.size());
    check("burst_ovf_count", mon_ovf, exp_ovf);
    drain();

    // Aborted frame leaves stored words untouched
    q = {8'hC3};
    frame(q, 0, 1'b0);
    q = {};
    frame(q, 5, 1'b0);
    check("abort_ferr_count", mon_ferr, exp_ferr);
    check("abort_level", {29'd0, fifo_level}, exp_q.size());
    q = {8'h3C};
    frame(q, 0, 1'b0);
    check("abort_next_level", {29'd0, fifo_level}, exp_q.size());
    drain();

    // Push and pop collide on a full FIFO
    q = {8'h10, 8'h11, 8'h12, 8'h13};
    frame(q, 0, 1'b0);
    q = {8'h77};
    frame(q, 0, 1'b1);
    check("collide_level", {29'd0, fifo_level}, exp_q.size());
    check("collide_no_ovf", mon_ovf, exp_ovf);
    drain();

    // Reset in the middle of a frame
    q = {8'h66};
    frame(q, 0, 1'b0);
    cs = 1'b0;
    tick(6);
    send_bits(8'hE7, 3, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("midrst_valid", {31'd0, rx_valid}, 32'd0);
    check("midrst_data", {24'd0, rx_data}, 32'd0);
    check("midrst_level", {29'd0, fifo_level}, 32'd0);
    check("midrst_flags", {29'd0, busy, frame_err, rx_overflow}, 32'd0);
    tick(3);
    cs  = 1'b1;
    sck = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(8);
    q = {8'h5A};
    frame(q, 0, 1'b0);
    check("midrst_next_level", {29'd0, fifo_level}, exp_q.size());
    check("midrst_next_head", {24'd0, rx_data}, 32'h5A);
    check("midrst_no_ferr", mon_ferr, exp_ferr);
    drain();

`ifdef SPI_SLAVE_RX_MISO_EN
    check("miso_idle", {31'd0, miso}, 32'd1);
    cap_byte = 1;
    q = {8'h12, 8'h34};
    frame(q, 0, 1'b0);
    cap_byte = -1;
    check("miso_echo", {24'd0, miso_cap}, 32'h12);
    check("miso_idle_after", {31'd0, miso}, 32'd1);
    drain();
`endif

    // Randomized frames with a randomly stalling consumer
    rand_rdy = 1'b1;
    for (int f = 0; f < 20; f++) begin
      int nb;
      int ab;
      q  = {};
      nb = $urandom_range(1, 3);
      for (int n = 0; n < nb; n++) q.push_back(8'($urandom()));
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      frame(q, ab, 1'b0);
    end
    rand_rdy = 1'b0;
    rx_ready = 1'b1;
    tick(20);
    rx_ready = 1'b0;
    check("rand_model_empty", exp_q.size(), 0);
    check("rand_level", {29'd0, fifo_level}, 32'd0);
    check("rand_ferr_count", mon_ferr, exp_ferr);
    check("rand_ovf_count", mon_ovf, exp_ovf);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
SPI slave receiver running on clk_50m. It oversamples external sck/cs/mosi from the board's SPI master (write-only, MSB first, data stable on sck rising edge). Received bytes go into a small first-word-fall-through (FWFT) FIFO, which presents them to the core on a valid/ready handshake. Frame errors and overflow are flagged.

Parameters:
DATA_W, 8, bits per word; shift register and FIFO width
FIFO_DEPTH, 4, FIFO entries; power of two, 2..16
SYNC_STAGES, 2, synchronizer flops on sck/cs/mosi; minimum 2

Ports:
clk_50m  input  1  system clock, 50 MHz
rst_n  input  1  asynchronous active-low reset
sck  input  1  SPI clock from master, asynchronous
cs  input  1  chip select, active low, asynchronous
mosi  input  1  serial data, MSB first, asynchronous
rx_ready  input  1  consumer accepts rx_data this cycle
rx_data  output  DATA_W  FIFO head word, valid when rx_valid=1
rx_valid  output  1  FIFO non-empty
rx_overflow  output  1  1-cycle pulse: completed word dropped, FIFO full
frame_err  output  1  1-cycle pulse: cs deasserted with partial word
busy  output  1  synchronized cs low (frame active)
fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, rst_n=0): rx_data=0, rx_valid=0, rx_overflow=0, frame_err=0, busy=0, fifo_level=0. FSM goes to IDLE, bit counter=0, shift reg=0. All synchronizer flops preset to 1 (sck idle high, cs inactive).
- Synchronization: sck, cs and mosi each pass through SYNC_STAGES flops; all three share the same delay.
- sck rise = synchronized sck high and previous synchronized sck low. cs fall/rise detected the same way.
- Input timing requirement: sck high and low phases each >= 3 clk_50m cycles (sck <= 8 MHz). mosi stable >= 1 cycle around the sck rising edge. Faster sck is unsupported.
- FSM states:
  - IDLE: busy=0, counter held at 0. On cs fall, go to ACTIVE and clear counter and shift register.
  - ACTIVE: busy=1. On each sck rise, shift_reg <= {shift_reg[DATA_W-2:0], mosi_s} and counter++.
    - When the counter reaches DATA_W-1 and another sck rise arrives, go to COMMIT.
    - On cs rise with counter != 0: pulse frame_err, discard partial word, go to IDLE.
    - On cs rise with counter == 0: go to IDLE, no error.
  - COMMIT (1 cycle): write the assembled word to the FIFO if not full; if full, pulse rx_overflow and drop the word. Clear counter. Return to ACTIVE if cs is still low, else IDLE.
- Multiple words per cs frame are allowed and back-to-back.
- Edges while cs is high are ignored. A sck rise in the same cycle as a cs rise is ignored.
- Latency: pin sck rise of the last bit to rx_valid=1 (empty FIFO) = SYNC_STAGES+3 clk_50m cycles.
- FIFO:
  - FWFT: rx_data is the head word whenever rx_valid=1. Pop on rx_valid & rx_ready.
  - Pointers have an extra wrap bit. Full = FIFO_DEPTH entries.
  - Simultaneous push and pop when full: the pop frees a slot, so the push succeeds and no overflow is flagged.
  - Pop when empty is ignored. rx_data holds its last value when empty.
- Reset mid-frame: partial word lost, FIFO emptied, no error pulse. After reset, the next cs fall starts a clean frame.

Optional Feature:
Macro SPI_SLAVE_RX_MISO_EN.
- Defined: adds output port miso (1 bit) that echoes the previous completed word, MSB first.
  - The echo word is loaded on cs fall and after each COMMIT.
  - miso = echo_reg[DATA_W-1]; echo_reg shifts left on each synchronized sck fall during ACTIVE.
  - miso is driven 1 when busy=0. Echo register resets to 0.
- Undefined: no miso port, no echo logic. Behaviour is otherwise identical.

Test Plan:
- Single frame: cs low, send 0xA5 MSB first at 2 MHz sck, cs high -> one rx_valid with rx_data=0xA5, frame_err=0, rx_overflow=0, fifo_level 1 then 0 after pop.
- Burst, rx_ready=0: one frame of 0x01,0x02,0x03,0x04,0x05 -> fifo_level=4. rx_overflow pulses once on 0x05. Raising rx_ready drains 0x01..0x04 in order.
- Abort: cs rises after 5 bits of 0xFF -> frame_err pulses once, FIFO unchanged. Next frame 0x3C received correctly.
- Push/pop collision: FIFO full, rx_ready=1 in the COMMIT cycle of 0x77 -> no overflow, fifo_level stays 4, 0x77 ends up last.
- Reset mid-frame: rst_n low after 3 bits -> all outputs 0 immediately. Subsequent frame 0x5A received correctly.
- MISO_EN build: frame of 0x12 then 0x34 -> second word's miso bits = 0x12 MSB first; miso=1 while cs high.
